// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU, feeding HI (remainder) and LO (quotient).
// Optional macro DIV_ZERO_FLAG_EN adds div_zero and suppresses HI/LO writes on divide by zero.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_we,
`ifdef DIV_ZERO_FLAG_EN
    output logic             lo_we,
    output logic             div_zero
`else
    output logic             lo_we
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, raw_q, hi_q, lo_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q, r_neg_q, dz_q, busy_q, done_q, we_q;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_d, quo_d, a_dvd, a_dvs, hi_d, lo_d;
`ifdef DIV_ZERO_FLAG_EN
    logic             dzf_q;
    assign div_zero = dzf_q;
`endif
    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign hi_we  = we_q;
    assign lo_we  = we_q;
    // One restoring step: trial subtract on the shifted partial remainder, WIDTH+1 bits wide.
    always_comb begin
        diff  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_d = diff[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        a_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        a_dvs = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
        lo_d  = dz_q ? '1 : q_neg_q ? -quo_q : quo_q;
        hi_d  = dz_q ? raw_q : r_neg_q ? -rem_q : rem_q;
    end
    // CALC runs WIDTH steps, then one sign-fix cycle that registers results on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            raw_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dzf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    rem_q   <= '0;
                    quo_q   <= a_dvd;
                    dvs_q   <= a_dvs;
                    raw_q   <= dividend;
                    q_neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_q <= is_signed & dividend[WIDTH-1];
                    dz_q    <= (divisor == '0);
                    cnt_q   <= CW'(WIDTH);
                    busy_q  <= 1'b1;
                    state_q <= CALC;
                end
                CALC: if (cnt_q != '0) begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
`ifdef DIV_ZERO_FLAG_EN
                    dzf_q   <= dz_q;
                    we_q    <= !dz_q;
                    if (!dz_q) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
`else
                    we_q    <= 1'b1;
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
`endif
                end
                DONE: begin
                    done_q  <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`ifdef DIV_ZERO_FLAG_EN
                    dzf_q   <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed self-checking bench for div_unit (WIDTH=32) against an arithmetic reference.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, hi_we, lo_we;
    logic [31:0] hi_out, lo_out;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .hi_out(hi_out), .lo_out(lo_out), .hi_we(hi_we),
`ifdef DIV_ZERO_FLAG_EN
        .lo_we(lo_we), .div_zero(div_zero)
`else
        .lo_we(lo_we)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncating division, remainder takes the dividend's sign; x/0 gives all-ones and the raw dividend.
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [31:0] eq, er;
        int lat;
        model(sgn, a, b, eq, er);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            chk("busy_calc", {31'b0, busy}, 32'd1);
            if (noise && lat == 5) begin
                start = 1'b1; is_signed = ~sgn; dividend = $urandom; divisor = $urandom;
            end
            if (noise && lat == 15) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("latency", lat, 33);
        chk("busy_done", {31'b0, busy}, 32'd1);
`ifdef DIV_ZERO_FLAG_EN
        if (b == 0) begin
            eq = prev_lo;
            er = prev_hi;
        end
        chk("div_zero", {31'b0, div_zero}, {31'b0, b == 0});
        chk("hi_we", {31'b0, hi_we}, {31'b0, b != 0});
        chk("lo_we", {31'b0, lo_we}, {31'b0, b != 0});
`else
        chk("hi_we", {31'b0, hi_we}, 32'd1);
        chk("lo_we", {31'b0, lo_we}, 32'd1);
`endif
        chk("lo_out", lo_out, eq);
        chk("hi_out", hi_out, er);
        @(posedge clk); #1;
        chk("done_pulse", {31'b0, done}, 32'd0);
        chk("we_pulse", {31'b0, hi_we | lo_we}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("lo_hold", lo_out, eq);
        chk("hi_hold", hi_out, er);
        prev_lo = eq;
        prev_hi = er;
    endtask

    initial begin
        bit seen;
        logic [31:0] b;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we", {31'b0, hi_we | lo_we}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 32'd100, 32'd7, 1'b0);
        run(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
        run(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1);
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run(1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
        run(1'b0, 32'd5, 32'd0, 1'b0);
        run(1'b1, 32'hFFFFFF00, 32'd0, 1'b0);
        run(1'b0, 32'd3, 32'd10, 1'b1);
        for (int i = 0; i < 24; i++) begin
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(1, 300));
            run(1'($urandom_range(0, 1)), 32'($urandom), b, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_hi", hi_out, 32'd0);
        chk("arst_lo", lo_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= done | hi_we | lo_we | busy;
        end
        chk("arst_quiet", {31'b0, seen}, 32'd0);
        prev_hi = '0;
        prev_lo = '0;
        run(1'b1, 32'hFFFFFC18, 32'd7, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider executing MIPS DIV/DIVU.
- Sits directly upstream of the HI and LO registers: remainder → HI data input, quotient → LO data input, write strobes drive their write enables.
- Control unit issues a start pulse and stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and ≥4.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin division; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  rs operand; sampled with start.
- divisor  input  WIDTH  rt operand; sampled with start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  output  1  one-cycle pulse; results valid.
- hi_out  output  WIDTH  remainder; feeds the HI register in_data.
- lo_out  output  WIDTH  quotient; feeds the LO register in_data.
- hi_we  output  1  HI write enable; pulses with done.
- lo_we  output  1  LO write enable; pulses with done.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, hi_we=0, lo_we=0, hi_out=0, lo_out=0, internal regs cleared.
- States: IDLE, CALC, DONE.
- IDLE: on the rising edge with start=1:
  - Latch operands and is_signed.
  - Signed mode: store |dividend|, |divisor|, q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend).
  - Unsigned mode: q_neg = r_neg = 0.
  - Load iteration counter = WIDTH; go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract divisor from rem using WIDTH+1 bits.
  - If non-negative: keep the difference and set quo LSB = 1; otherwise set quo LSB = 0.
  - Decrement counter; after WIDTH steps go to DONE.
- DONE: lasts exactly one cycle.
  - Register lo_out = q_neg ? −quo : quo and hi_out = r_neg ? −rem : rem.
  - Assert done = hi_we = lo_we = 1 for that cycle, then return to IDLE.
- Latency: if start is sampled at edge T, done is high during the cycle after edge T+WIDTH+1 (33 cycles for WIDTH=32). Back-to-back start is accepted on the edge that leaves DONE → IDLE plus one cycle; i.e. start is only honoured while state=IDLE.
- hi_out/lo_out hold the last result until the next DONE; they are not cleared on start.
- start while busy: ignored, no effect on the in-flight operation.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (falls out of the magnitude algorithm; no special case).
- Divide by zero (macro absent): forced result lo={WIDTH{1}}, hi=dividend (raw sampled value), both modes; hi_we/lo_we pulse normally; takes full latency.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- Reset mid-CALC: operation aborted, no done/we pulse, outputs zero.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - Adds output port div_zero (1 bit, reset 0), which pulses together with done when the sampled divisor was 0.
  - In that case hi_we=lo_we=0, so HI/LO keep their old values, and hi_out/lo_out are not updated.
  - Latency is unchanged.
- Undefined: no div_zero port; forced divide-by-zero result written as above.

Test Plan:
- DIVU 100/7 → after 33 cycles: done=1, lo_out=0x0000000E, hi_out=0x00000002, hi_we=lo_we=1 for exactly 1 cycle.
- DIV −7/2 (0xFFFFFFF9/0x00000002) → lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; DIV 7/−2 → lo=0xFFFFFFFD, hi=0x00000001.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- DIVU 5/0 → macro off: lo=0xFFFFFFFF, hi=5, we pulsed; macro on: div_zero=1, hi_we=lo_we=0, outputs retain previous result.
- start re-asserted during CALC with different operands → ignored; first result delivered unchanged at cycle 33; busy stays 1 throughout.
- rst asserted at cycle 10 of CALC → busy, done, outputs = 0 immediately (async); no done pulse afterward; new start after deassert completes normally.
